i2c_arbiter: RTL and testbench

I2C_ARBITER -- requirements
Module: i2c_arbiter

---
 rtl/i2c_arbiter.sv | 179 +++++++++++++++++
 tb/tb_i2c_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_arbiter.sv
// i2c_arbiter: shares one i2c_basic master among N_CLIENTS requesters using
// round-robin arbitration, optional bus locking and a WAIT-state timeout.
module i2c_arbiter #(
    parameter int N_CLIENTS      = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [N_CLIENTS-1:0]    req_start,
    input  logic [N_CLIENTS-1:0]    req_lock,
    input  logic [7*N_CLIENTS-1:0]  req_addr,
    input  logic [2*N_CLIENTS-1:0]  req_num_wr,
    input  logic [24*N_CLIENTS-1:0] req_wr_data,
    input  logic [2*N_CLIENTS-1:0]  req_num_rd,
    output logic [N_CLIENTS-1:0]    req_done,
    output logic [N_CLIENTS-1:0]    req_err,
    output logic [15:0]             rd_data,
    output logic [N_CLIENTS-1:0]    grant,
    output logic                    busy,
    output logic                    i2c_start,
    output logic [6:0]              i2c_addr,
    output logic [1:0]              i2c_num_wr_bytes,
    output logic [7:0]              i2c_wr_data0,
    output logic [7:0]              i2c_wr_data1,
    output logic [7:0]              i2c_wr_data2,
    output logic [1:0]              i2c_num_rd_bytes,
    input  logic                    i2c_done,
    input  logic [7:0]              i2c_rd_data0,
    input  logic [7:0]              i2c_rd_data1
);
    localparam int GW = $clog2(N_CLIENTS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                 state_r;
    logic [N_CLIENTS-1:0]   pending_r;
    logic [GW-1:0]          last_grant_r;
    logic [GW-1:0]          g_idx_r;
    logic                   lock_valid_r;
    logic [GW-1:0]          lock_owner_r;
    logic [19:0]            timer_r;
    logic [N_CLIENTS-1:0]   grant_r;
    logic [N_CLIENTS-1:0]   req_done_r;
    logic [N_CLIENTS-1:0]   req_err_r;
    logic [15:0]            rd_data_r;
    logic [6:0]             addr_r;
    logic [1:0]             num_wr_r;
    logic [1:0]             num_rd_r;
    logic [23:0]            wr_data_r;

    logic                   lock_hold_s;
    logic [N_CLIENTS-1:0]   eligible_s;
    logic                   win_found_s;
    logic [GW-1:0]          win_idx_s;
    logic [GW-1:0]          cand_s;
    logic                   hit_s;
    logic [N_CLIENTS-1:0]   clr_mask_s;
    logic                   zero_len_s;

    function automatic logic [N_CLIENTS-1:0] onehot(input logic [GW-1:0] idx);
        logic [N_CLIENTS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Winner selection: a held lock restricts eligibility to its owner, otherwise round-robin after last_grant.
    always_comb begin
        lock_hold_s = lock_valid_r && req_lock[lock_owner_r];
        eligible_s  = lock_hold_s ? (pending_r & onehot(lock_owner_r)) : pending_r;
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand_s      = '0;
        hit_s       = 1'b0;
        for (int k = 1; k <= N_CLIENTS; k++) begin
            cand_s      = GW'((int'(last_grant_r) + k) % N_CLIENTS);
            hit_s       = eligible_s[cand_s] && !win_found_s;
            win_idx_s   = hit_s ? cand_s : win_idx_s;
            win_found_s = win_found_s || hit_s;
        end
        clr_mask_s = ((state_r == ST_IDLE) && win_found_s) ? onehot(win_idx_s) : '0;
    end

    assign zero_len_s = (num_wr_r == 2'd0) && (num_rd_r == 2'd0);

    // Arbiter FSM together with the pending set, lock tracking and every registered output.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r      <= ST_IDLE;
            pending_r    <= '0;
            last_grant_r <= GW'(N_CLIENTS - 1);
            g_idx_r      <= '0;
            lock_valid_r <= 1'b0;
            lock_owner_r <= '0;
            timer_r      <= 20'd0;
            grant_r      <= '0;
            req_done_r   <= '0;
            req_err_r    <= '0;
            rd_data_r    <= 16'h0000;
            addr_r       <= 7'h00;
            num_wr_r     <= 2'd0;
            num_rd_r     <= 2'd0;
            wr_data_r    <= 24'h000000;
        end else begin
            pending_r  <= (pending_r | req_start) & ~clr_mask_s;
            req_done_r <= '0;
            req_err_r  <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (!lock_hold_s) begin
                        lock_valid_r <= 1'b0;
                    end
                    if (win_found_s) begin
                        addr_r       <= req_addr[int'(win_idx_s)*7 +: 7];
                        num_wr_r     <= req_num_wr[int'(win_idx_s)*2 +: 2];
                        num_rd_r     <= req_num_rd[int'(win_idx_s)*2 +: 2];
                        wr_data_r    <= req_wr_data[int'(win_idx_s)*24 +: 24];
                        grant_r      <= onehot(win_idx_s);
                        last_grant_r <= win_idx_s;
                        g_idx_r      <= win_idx_s;
                        state_r      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    timer_r <= 20'(TIMEOUT_CYCLES);
                    // An empty transaction never touches the bus and completes at once.
                    if (zero_len_s) begin
                        req_done_r   <= grant_r;
                        grant_r      <= '0;
                        lock_valid_r <= req_lock[g_idx_r];
                        lock_owner_r <= g_idx_r;
                        state_r      <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    timer_r <= timer_r - 20'd1;
                    if (i2c_done) begin
                        rd_data_r    <= {i2c_rd_data1, i2c_rd_data0};
                        req_done_r   <= grant_r;
                        grant_r      <= '0;
                        lock_valid_r <= req_lock[g_idx_r];
                        lock_owner_r <= g_idx_r;
                        state_r      <= ST_IDLE;
                    end else if (timer_r <= 20'd1) begin
                        req_done_r   <= grant_r;
                        req_err_r    <= grant_r;
                        grant_r      <= '0;
                        lock_valid_r <= 1'b0;
                        state_r      <= ST_IDLE;
                    end
                end
                default: begin
                    grant_r <= '0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign i2c_start        = (state_r == ST_ISSUE) && !zero_len_s;
    assign busy             = (state_r != ST_IDLE);
    assign grant            = grant_r;
    assign req_done         = req_done_r;
    assign req_err          = req_err_r;
    assign rd_data          = rd_data_r;
    assign i2c_addr         = addr_r;
    assign i2c_num_wr_bytes = num_wr_r;
    assign i2c_num_rd_bytes = num_rd_r;
    assign i2c_wr_data0     = wr_data_r[7:0];
    assign i2c_wr_data1     = wr_data_r[15:8];
    assign i2c_wr_data2     = wr_data_r[23:16];

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb_i2c_arbiter: transaction-level reference model with a scripted i2c responder,
// directed vector table, arbitration/lock/reset sequences and random traffic.
module tb_i2c_arbiter;
    localparam int N = 4;
    localparam int T = 12;

    logic            clk = 1'b0;
    logic            resetn;
    logic [N-1:0]    req_start, req_lock;
    logic [7*N-1:0]  req_addr;
    logic [2*N-1:0]  req_num_wr, req_num_rd;
    logic [24*N-1:0] req_wr_data;
    logic [N-1:0]    req_done, req_err, grant;
    logic [15:0]     rd_data;
    logic            busy, i2c_start, i2c_done;
    logic [6:0]      i2c_addr;
    logic [1:0]      i2c_num_wr_bytes, i2c_num_rd_bytes;
    logic [7:0]      i2c_wr_data0, i2c_wr_data1, i2c_wr_data2, i2c_rd_data0, i2c_rd_data1;

    i2c_arbiter #(.N_CLIENTS(N), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .resetn(resetn), .req_start(req_start), .req_lock(req_lock),
        .req_addr(req_addr), .req_num_wr(req_num_wr), .req_wr_data(req_wr_data),
        .req_num_rd(req_num_rd), .req_done(req_done), .req_err(req_err),
        .rd_data(rd_data), .grant(grant), .busy(busy), .i2c_start(i2c_start),
        .i2c_addr(i2c_addr), .i2c_num_wr_bytes(i2c_num_wr_bytes),
        .i2c_wr_data0(i2c_wr_data0), .i2c_wr_data1(i2c_wr_data1), .i2c_wr_data2(i2c_wr_data2),
        .i2c_num_rd_bytes(i2c_num_rd_bytes), .i2c_done(i2c_done),
        .i2c_rd_data0(i2c_rd_data0), .i2c_rd_data1(i2c_rd_data1)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    // Reference model state: pending set, rotation pointer, lock and the one in-flight transaction.
    logic [3:0]  m_pend, prev_grant;
    int          m_last, m_lock_own, own, s_cyc, due, done_at;
    bit          m_lock_v, act, err_x, zero_x, idle_prev;
    logic [15:0] m_rd, resp_rd, dir_rd;
    logic [6:0]  m_addr;
    logic [1:0]  m_nw, m_nr;
    logic [23:0] m_wd;
    int          glog[$];
    int          obs_start_cyc, obs_done_cyc;
    bit          obs_err, use_dir;
    int          dir_delay;

    typedef struct {
        int client; logic [6:0] addr; logic [1:0] nw; logic [23:0] wd; logic [1:0] nr;
        int delay; logic [15:0] rdv; int exp_start; int exp_done; bit exp_err; logic [15:0] exp_rd;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string nm, input int act_v, input int exp_v);
        n_cmp++;
        if (act_v != exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act_v, exp_v, cyc);
        end
    endtask

    task automatic set_client(input int c, input logic [6:0] a, input logic [1:0] nw,
                              input logic [23:0] wd, input logic [1:0] nr);
        req_addr[c*7 +: 7]     = a;
        req_num_wr[c*2 +: 2]   = nw;
        req_wr_data[c*24 +: 24] = wd;
        req_num_rd[c*2 +: 2]   = nr;
    endtask

    task automatic model_reset();
        m_pend = 4'b0000; m_last = N - 1; m_lock_v = 1'b0; m_lock_own = 0; act = 1'b0;
        m_rd = 16'h0000; m_addr = 7'h00; m_nw = 2'd0; m_nr = 2'd0; m_wd = 24'h0;
        zero_x = 1'b0; err_x = 1'b0; s_cyc = -100; due = -100; done_at = -1;
        idle_prev = 1'b1; prev_grant = 4'b0000;
    endtask

    // Drive req_start for one cycle, then observe mid-next-cycle and compare everything to the model.
    task automatic step(input logic [3:0] st);
        logic [3:0] clr, elig, exp_done, exp_err;
        bit found;
        int win, d, idx;
        req_start = st;
        @(negedge clk);
        cyc++;
        clr = 4'b0000;
        exp_done = 4'b0000;
        exp_err = 4'b0000;
        if (act && cyc == due) begin
            exp_done = 4'b0001 << own;
            exp_err  = err_x ? exp_done : 4'b0000;
            if (!err_x && !zero_x) m_rd = resp_rd;
            if (err_x) m_lock_v = 1'b0;
            else begin m_lock_v = req_lock[own]; m_lock_own = own; end
            act = 1'b0;
        end
        if (!act && idle_prev) begin
            if (m_lock_v && !req_lock[m_lock_own]) m_lock_v = 1'b0;
            elig = m_lock_v ? (m_pend & (4'b0001 << m_lock_own)) : m_pend;
            found = 1'b0;
            win = 0;
            for (int k = 1; k <= N; k++) begin
                idx = (m_last + k) % N;
                if (!found && elig[idx]) begin found = 1'b1; win = idx; end
            end
            if (found) begin
                act = 1'b1; own = win; m_last = win; s_cyc = cyc;
                clr = 4'b0001 << win;
                m_pend = m_pend & ~clr;
                m_addr = req_addr[win*7 +: 7];
                m_nw   = req_num_wr[win*2 +: 2];
                m_nr   = req_num_rd[win*2 +: 2];
                m_wd   = req_wr_data[win*24 +: 24];
                zero_x = (m_nw == 2'd0) && (m_nr == 2'd0);
                d       = use_dir ? dir_delay : int'($urandom_range(1, T + 3));
                resp_rd = use_dir ? dir_rd : 16'($urandom);
                if (zero_x) begin due = cyc + 1; err_x = 1'b0; done_at = -1; end
                else if (d >= 1 && d <= T) begin due = cyc + d + 1; err_x = 1'b0; done_at = cyc + d; end
                else begin due = cyc + T + 1; err_x = 1'b1; done_at = -1; end
            end
        end
        m_pend = m_pend | (st & ~clr);
        chk("req_done", int'(req_done), int'(exp_done));
        chk("req_err", int'(req_err), int'(exp_err));
        chk("grant", int'(grant), act ? (1 << own) : 0);
        chk("busy", int'(busy), int'(act));
        chk("i2c_start", int'(i2c_start), int'(act && cyc == s_cyc && !zero_x));
        chk("i2c_addr", int'(i2c_addr), int'(m_addr));
        chk("i2c_counts", int'({i2c_num_wr_bytes, i2c_num_rd_bytes}), int'({m_nw, m_nr}));
        chk("i2c_wr_data", int'({i2c_wr_data2, i2c_wr_data1, i2c_wr_data0}), int'(m_wd));
        chk("rd_data", int'(rd_data), int'(m_rd));
        if (grant != 4'b0000 && prev_grant == 4'b0000) begin
            for (int k = 0; k < N; k++) if (grant[k]) glog.push_back(k);
        end
        if (i2c_start) obs_start_cyc = cyc;
        if (req_done != 4'b0000) begin obs_done_cyc = cyc; obs_err = (req_err != 4'b0000); end
        prev_grant = grant;
        idle_prev = !act;
        i2c_done = (cyc == done_at);
        {i2c_rd_data1, i2c_rd_data0} = resp_rd;
    endtask

    task automatic apply_reset_check();
        resetn = 1'b0;
        #1;
        chk("rst_grant", int'(grant), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done_err", int'({req_done, req_err}), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        chk("rst_i2c_start", int'(i2c_start), 0);
        chk("rst_i2c_fields", int'({i2c_addr, i2c_num_wr_bytes, i2c_num_rd_bytes}), 0);
        chk("rst_i2c_wr_data", int'({i2c_wr_data2, i2c_wr_data1, i2c_wr_data0}), 0);
        model_reset();
        req_start = 4'b0000; req_lock = 4'b0000; i2c_done = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic drain(input int maxc);
        int k = 0;
        while ((act || m_pend != 4'b0000) && k < maxc) begin step(4'b0000); k++; end
        chk("drain_bound", int'(k < maxc), 1);
    endtask

    initial begin
        int t, k;
        int exp_ord[5] = '{0, 1, 2, 3, 0};
        logic [3:0] st;
        tbl[0] = '{1, 7'h20, 2'd3, 24'hAA5502, 2'd0, 10, 16'hBEEF, 2, 13, 1'b0, 16'hBEEF};
        tbl[1] = '{3, 7'h50, 2'd1, 24'h000011, 2'd2, 3, 16'h1234, 2, 6, 1'b0, 16'h1234};
        tbl[2] = '{0, 7'h7F, 2'd0, 24'h000000, 2'd1, T, 16'h5A5A, 2, 15, 1'b0, 16'h5A5A};
        tbl[3] = '{2, 7'h11, 2'd2, 24'h00C3A5, 2'd0, 0, 16'hFFFF, 2, 15, 1'b1, 16'h5A5A};
        tbl[4] = '{1, 7'h33, 2'd0, 24'h000000, 2'd0, 0, 16'h7777, -1, 3, 1'b0, 16'h5A5A};
        tbl[5] = '{2, 7'h01, 2'd0, 24'h000000, 2'd2, 1, 16'h0F0F, 2, 4, 1'b0, 16'h0F0F};
        resetn = 1'b0; req_start = '0; req_lock = '0; req_addr = '0; req_num_wr = '0;
        req_num_rd = '0; req_wr_data = '0; i2c_done = 1'b0; i2c_rd_data0 = 8'h00; i2c_rd_data1 = 8'h00;
        use_dir = 1'b1; dir_delay = 2; dir_rd = 16'h0000;
        @(negedge clk);
        apply_reset_check();

        // Directed single-client vectors with absolute latency expectations.
        for (int i = 0; i < 6; i++) begin
            set_client(tbl[i].client, tbl[i].addr, tbl[i].nw, tbl[i].wd, tbl[i].nr);
            dir_delay = tbl[i].delay; dir_rd = tbl[i].rdv;
            obs_start_cyc = -1; obs_done_cyc = -1; obs_err = 1'b0;
            t = cyc;
            step(4'b0001 << tbl[i].client);
            k = 0;
            while (obs_done_cyc < 0 && k < 60) begin step(4'b0000); k++; end
            chk("tbl_start_ofs", (obs_start_cyc < 0) ? -1 : obs_start_cyc - t, tbl[i].exp_start);
            chk("tbl_done_ofs", (obs_done_cyc < 0) ? -1 : obs_done_cyc - t, tbl[i].exp_done);
            chk("tbl_err", int'(obs_err), int'(tbl[i].exp_err));
            chk("tbl_rd_data", int'(rd_data), int'(tbl[i].exp_rd));
        end

        // All clients at once, then client 0 again: expect 0,1,2,3,0.
        apply_reset_check();
        for (int c = 0; c < N; c++) set_client(c, 7'(8'h10 + c), 2'd1, 24'(c), 2'd0);
        dir_delay = 2; glog.delete();
        step(4'b1111);
        k = 0;
        while (glog.size() < 1 && k < 20) begin step(4'b0000); k++; end
        step(4'b0001);
        while (glog.size() < 5 && k < 200) begin step(4'b0000); k++; end
        drain(100);
        chk("order_count", glog.size(), 5);
        for (int i = 0; i < 5; i++) if (i < glog.size()) chk("order_entry", glog[i], exp_ord[i]);

        // Client 2 holds the lock over a write and a read while client 0 waits.
        apply_reset_check();
        glog.delete();
        req_lock[2] = 1'b1;
        set_client(2, 7'h48, 2'd1, 24'h000000, 2'd0);
        set_client(0, 7'h0A, 2'd1, 24'h000099, 2'd0);
        dir_delay = 2; dir_rd = 16'hAAAA;
        step(4'b0100); step(4'b0000); step(4'b0001);
        k = 0;
        while (!(glog.size() == 1 && !act) && k < 40) begin step(4'b0000); k++; end
        step(4'b0000); step(4'b0000);
        set_client(2, 7'h48, 2'd0, 24'h000000, 2'd2);
        dir_delay = 3; dir_rd = 16'h1234;
        step(4'b0100);
        k = 0;
        while (!(glog.size() == 2 && !act) && k < 40) begin step(4'b0000); k++; end
        repeat (5) step(4'b0000);
        chk("lock_blocks_other", glog.size(), 2);
        chk("lock_rd_data", int'(rd_data), 16'h1234);
        req_lock[2] = 1'b0;
        k = 0;
        while (glog.size() < 3 && k < 20) begin step(4'b0000); k++; end
        chk("lock_release_serves", (glog.size() >= 3) ? glog[2] : -1, 0);
        drain(60);

        // Reset in the middle of WAIT: everything clears at once and no completion follows.
        set_client(1, 7'h21, 2'd1, 24'h000042, 2'd0);
        dir_delay = 0;
        step(4'b0010);
        repeat (4) step(4'b0000);
        chk("wait_before_rst", int'(busy), 1);
        apply_reset_check();
        repeat (T + 4) step(4'b0000);

        // Random traffic with random locks, lengths and responder delays.
        use_dir = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            st = 4'b0000;
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 15) == 0) req_lock[c] = ~req_lock[c];
                if ($urandom_range(0, 5) == 0) begin
                    st[c] = 1'b1;
                    set_client(c, 7'($urandom), 2'($urandom_range(0, 3)), 24'($urandom),
                               2'($urandom_range(0, 2)));
                end
            end
            step(st);
        end
        req_lock = 4'b0000;
        drain(400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
